// File: rtl/hmac_spongent_arbiter.sv
// -----------------------------------------------------------------------------
// hmac_spongent_arbiter
//
// Shares one hmac_spongent engine between NREQ requesters. A round-robin
// arbiter picks a winner, its key/message slices are latched and driven to the
// engine. The engine reset/start is then sequenced, completion or timeout is
// watched for, and the digest is returned with a one-hot done pulse.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   req          per-requester request (level)
//   key_i        NREQ keys, slice i belongs to requester i
//   msg_i        NREQ messages, slice i belongs to requester i
//   gnt          one-hot 1-cycle pulse: inputs of that requester accepted
//   done         one-hot 1-cycle pulse: job of that requester finished
//   err_o        1-cycle pulse coincident with done when the job timed out
//   digest_o     result, valid from done, held until the next normal done
//   busy         high in every state except IDLE
//   eng_rst      engine reset/start, active-high (1 = hold engine in reset)
//   eng_key      latched key to the engine
//   eng_msg      latched message to the engine
//   eng_digest   engine digest
//   eng_end      engine end flag, level, held until eng_rst
//   dbg_state_o  current FSM state (0 IDLE, 1 LOAD, 2 RUN, 3 DONE, 4 RECOVER)
//
// Handshake: a requester raises req[i] and keeps key/msg stable; the cycle in
// which gnt[i] is high is the transfer cycle (req acts as valid, gnt as ready
// and valid&ready happens only there). key/msg are sampled only in that cycle.
// Dropping req before gnt withdraws the request; keeping req high after gnt
// is a new request.
// -----------------------------------------------------------------------------
module hmac_spongent_arbiter #(
    parameter int N           = 256,
    parameter int KEY_WIDTH   = 64,
    parameter int INPUT_WIDTH = 64,
    parameter int NREQ        = 4,
    parameter int TIMEOUT     = 4096,
    parameter int RECOVER_CYC = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*KEY_WIDTH-1:0]   key_i,
    input  logic [NREQ*INPUT_WIDTH-1:0] msg_i,
    output logic [NREQ-1:0]             gnt,
    output logic [NREQ-1:0]             done,
    output logic                        err_o,
    output logic [N-1:0]                digest_o,
    output logic                        busy,
    output logic                        eng_rst,
    output logic [KEY_WIDTH-1:0]        eng_key,
    output logic [INPUT_WIDTH-1:0]      eng_msg,
    input  logic [N-1:0]                eng_digest,
    input  logic                        eng_end,
    output logic [2:0]                  dbg_state_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam int RW = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [RW-1:0] REC_LAST = RW'(RECOVER_CYC - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RUN     = 3'd2,
        S_DONE    = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [RW-1:0]          rec_q, rec_d;
    logic [PW-1:0]          owner_q, owner_d;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [N-1:0]           digest_q, digest_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic [INPUT_WIDTH-1:0] msg_q, msg_d;

    logic                   win_found;
    logic [PW-1:0]          win_idx;
    logic [PW-1:0]          next_ptr;
    logic [NREQ-1:0]        owner_oh;
    logic [NREQ-1:0]        gnt_c;
    logic [NREQ-1:0]        done_c;
    logic                   err_c;

    // Round-robin pick: first set req bit scanning upward from rr_ptr. The
    // wrap is an explicit subtraction so NREQ need not be a power of two.
    always_comb begin
        int           idx;
        logic [PW-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = PW'(idx);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign next_ptr = (owner_q == PTR_LAST) ? '0 : owner_q + PW'(1);
    assign owner_oh = NREQ'(1) << owner_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rec_d    = rec_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        digest_d = digest_q;
        key_d    = key_q;
        msg_d    = msg_q;
        gnt_c    = '0;
        done_c   = '0;
        err_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_c   = NREQ'(1) << win_idx;
                    owner_d = win_idx;
                    key_d   = key_i[int'(win_idx) * KEY_WIDTH +: KEY_WIDTH];
                    msg_d   = msg_i[int'(win_idx) * INPUT_WIDTH +: INPUT_WIDTH];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // Engine inputs settle for one cycle while still in reset.
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                // End takes priority over a timeout in the same cycle.
                if (eng_end) begin
                    digest_d = eng_digest;
                    state_d  = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rec_d   = '0;
                    state_d = S_RECOVER;
                end
            end
            S_DONE: begin
                done_c   = owner_oh;
                rr_ptr_d = next_ptr;
                state_d  = S_IDLE;
            end
            S_RECOVER: begin
                if (rec_q == REC_LAST) begin
                    done_c   = owner_oh;
                    err_c    = 1'b1;
                    rr_ptr_d = next_ptr;
                    state_d  = S_IDLE;
                end else begin
                    rec_d = rec_q + RW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rec_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            digest_q <= '0;
            key_q    <= '0;
            msg_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rec_q    <= rec_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            digest_q <= digest_d;
            key_q    <= key_d;
            msg_q    <= msg_d;
        end
    end

    // gnt is combinational on req; masking with rst keeps it low while the
    // block is held in reset even if requesters are already asserting req.
    assign gnt         = rst ? gnt_c : '0;
    assign done        = done_c;
    assign err_o       = err_c;
    assign digest_o    = digest_q;
    assign busy        = (state_q != S_IDLE);
    assign eng_rst     = (state_q != S_RUN);
    assign eng_key     = key_q;
    assign eng_msg     = msg_q;
    assign dbg_state_o = state_q;

endmodule
